// File: rtl/rq_pkg.sv
// Shared constants and types for the Rq coefficient datapath.
package rq_pkg;

  localparam int unsigned COEF_W_DEF = 13;
  localparam int unsigned Q          = 8192;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rq_coeff_arb_if.sv
// Multi-channel coefficient input bundle plus the merged output stream.
interface rq_coeff_arb_if
  import rq_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned COEF_W = COEF_W_DEF
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*COEF_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;

  logic                     out_valid;
  logic [COEF_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  // Upstream sources and downstream sink
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

endinterface

// File: rtl/rq_coeff_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx_c,
  output logic              gnt_vld_c
);

  // Rotating priority search starting at ptr
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld_c && req[idx]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rq_coeff_arb.sv
// N-channel coefficient merger with packet locking and a registered output stage.
module rq_coeff_arb
  import rq_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned COEF_W = COEF_W_DEF,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  rq_coeff_arb_if.slave     bus,
  input  logic              mode,
  input  logic [CH_W-1:0]   sel,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              lock_rr_q, lock_rr_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [COEF_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              busy_q, busy_d;

  logic              load_c;
  logic              grant_ok_c;
  logic              rr_mode_c;
  logic              xfer_c;
  logic              last_c;
  logic [CH_W-1:0]   g_c;
  logic [NUM_CH-1:0] in_ready_c;
  logic [CH_W-1:0]   pick_idx_c;
  logic              pick_vld_c;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .gnt_idx_c (pick_idx_c),
    .gnt_vld_c (pick_vld_c)
  );

  // Grant selection and per-channel ready; no acceptance while reset is held
  always_comb begin
    load_c     = !out_valid_q || bus.out_ready;
    g_c        = lock_ch_q;
    grant_ok_c = 1'b1;
    rr_mode_c  = lock_rr_q;
    if (state_q == IDLE) begin
      rr_mode_c = mode;
      if (mode) begin
        g_c        = pick_idx_c;
        grant_ok_c = pick_vld_c;
      end else begin
        g_c        = sel;
        grant_ok_c = (32'(sel) < NUM_CH);
      end
    end
    in_ready_c = '0;
    if (rst_n && load_c && grant_ok_c) in_ready_c = NUM_CH'(1) << g_c;
    xfer_c = in_ready_c[g_c] && bus.in_valid[g_c];
    last_c = bus.in_last[g_c];
  end

  // Next state for the lock FSM, round-robin pointer and output register
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    lock_rr_d   = lock_rr_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (load_c) out_valid_d = xfer_c;

    if (xfer_c) begin
      out_data_d = bus.in_data[32'(g_c)*COEF_W +: COEF_W];
      out_last_d = last_c;
      out_ch_d   = g_c;
      if (last_c && rr_mode_c)
        rr_ptr_d = (g_c == CH_W'(NUM_CH-1)) ? '0 : g_c + CH_W'(1);
      unique case (state_q)
        IDLE: begin
          if (!last_c) begin
            state_d   = LOCKED;
            lock_ch_d = g_c;
            lock_rr_d = mode;
          end
        end
        LOCKED: begin
          if (last_c) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      lock_rr_q   <= 1'b0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      lock_rr_q   <= lock_rr_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rq_coeff_arb.sv
// Scoreboard bench for rq_coeff_arb: directed packets, queued expectations, negedge monitor.
module tb_rq_coeff_arb;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned COEF_W = 13;
  localparam int unsigned DEPTH  = 64;

  typedef struct packed {
    logic [COEF_W-1:0] d;
    logic              l;
    logic [1:0]        ch;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic        busy;

  rq_coeff_arb_if #(.NUM_CH(NUM_CH), .COEF_W(COEF_W)) bus ();

  rq_coeff_arb #(.NUM_CH(NUM_CH), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mode  (mode),
    .sel   (sel),
    .busy  (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;
  int last_pop_cyc = 0;
  int prev_pop_cyc = 0;

  exp_t exp_q[$];
  logic [COEF_W-1:0] sd [NUM_CH][DEPTH];
  logic              sl [NUM_CH][DEPTH];
  int                sn [NUM_CH];
  int                sh [NUM_CH];
  logic [NUM_CH-1:0] mask;
  logic              idle_chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NUM_CH; i++) if (sh[i] < sn[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic src_add(input int ch, input int d, input bit l);
    sd[ch][sn[ch]] = COEF_W'(d);
    sl[ch][sn[ch]] = l;
    sn[ch]++;
  endtask

  task automatic exp_add(input int ch, input int d, input bit l);
    exp_t e;
    e.d  = COEF_W'(d);
    e.l  = l;
    e.ch = 2'(ch);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(src_empty() && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drain"}, 32'(src_empty() && exp_q.size() == 0), 32'd1);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_pops", 32'(pops >= target), 32'd1);
  endtask

  // Source driver: retire accepted beats at the edge, present the next head after it
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NUM_CH; i++)
        if (bus.in_valid[i] && bus.in_ready[i]) sh[i]++;
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sh[i] < sn[i]) begin
          bus.in_valid[i] = 1'b1;
          bus.in_data[i*COEF_W +: COEF_W] = sd[i][sh[i]];
          bus.in_last[i] = sl[i][sh[i]];
        end else begin
          bus.in_valid[i] = 1'b0;
          bus.in_data[i*COEF_W +: COEF_W] = '0;
          bus.in_last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: ready legality every cycle, scoreboard compare on each consumed beat
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready_onehot", 32'($onehot0(bus.in_ready)), 32'd1);
      chk("in_ready_mask", 32'(bus.in_ready & ~mask), 32'd0);
      if (idle_chk) chk("idle_busy", 32'(busy), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {bus.out_data, bus.out_last, bus.out_ch}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({bus.out_data, bus.out_last, bus.out_ch}), 32'(e));
        end
        pops++;
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    int base;
    int n;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    mode     = 1'b1;
    sel      = 2'd0;
    rst_n    = 1'b0;
    mask     = '0;
    idle_chk = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sn[i] = 0;
      sh[i] = 0;
    end

    // Reset values
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Fixed select on channel 2
    mode = 1'b0; sel = 2'd2; mask = 4'b0100;
    src_add(2, 'h0001, 0); src_add(2, 'h1FFF, 0); src_add(2, 'h0AAA, 1);
    exp_add(2, 'h0001, 0); exp_add(2, 'h1FFF, 0); exp_add(2, 'h0AAA, 1);
    wait_drain("fixed", 50);
    chk("fixed_busy_end", 32'(busy), 32'd0);

    // Round-robin over all channels, two-beat packets, pointer wraps to 0
    mode = 1'b1; mask = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      src_add(c, 'h100 + c*16, 0); src_add(c, 'h101 + c*16, 1);
    end
    src_add(0, 'h500, 0); src_add(0, 'h501, 1);
    for (int c = 0; c < 4; c++) begin
      exp_add(c, 'h100 + c*16, 0); exp_add(c, 'h101 + c*16, 1);
    end
    exp_add(0, 'h500, 0); exp_add(0, 'h501, 1);
    wait_drain("rr", 100);

    // Backpressure for three cycles inside a channel-1 packet
    for (int k = 0; k < 5; k++) begin
      src_add(1, 'h0C01 + k, k == 4);
      exp_add(1, 'h0C01 + k, k == 4);
    end
    base = pops;
    wait_pops(base + 2, 50);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(exp_q[0].d));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    wait_drain("stall", 50);

    // Mode/sel changes while locked on channel 1 only take effect afterwards
    mode = 1'b0; sel = 2'd1; mask = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      src_add(1, 'h0D00 + k, k == 5);
      exp_add(1, 'h0D00 + k, k == 5);
    end
    src_add(3, 'h0D33, 1);
    src_add(0, 'h0E00, 1);
    exp_add(3, 'h0D33, 1);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    chk("lock_busy", 32'(busy), 32'd1);
    mode = 1'b1;
    step();
    sel = 2'd3;
    step();
    mode = 1'b0; mask = 4'b1010;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    chk("lock_sequence_done", 32'(exp_q.size()), 32'd0);
    sel = 2'd0; mask = 4'b0001;
    exp_add(0, 'h0E00, 1);
    wait_drain("lock", 50);

    // Back-to-back single-beat packets on 3 then 0; pointer ends at 1
    mode = 1'b1; mask = 4'b1001; idle_chk = 1'b1;
    src_add(3, 'h0F03, 1); src_add(0, 'h0F00, 1);
    exp_add(3, 'h0F03, 1); exp_add(0, 'h0F00, 1);
    wait_drain("single", 50);
    chk("no_bubble", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);
    mask = 4'b0111;
    src_add(0, 'h0F10, 1); src_add(1, 'h0F11, 1); src_add(2, 'h0F12, 1);
    exp_add(1, 'h0F11, 1); exp_add(2, 'h0F12, 1); exp_add(0, 'h0F10, 1);
    wait_drain("ptr_one", 50);
    idle_chk = 1'b0;

    // Asynchronous reset in the middle of a channel-2 packet
    mask = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      src_add(2, 'h0A10 + k, k == 3);
      exp_add(2, 'h0A10 + k, k == 3);
    end
    base = pops;
    wait_pops(base + 2, 30);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'd0);
    chk("arst_out_last",  32'(bus.out_last),  32'd0);
    chk("arst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("arst_busy",      32'(busy),          32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) sh[i] = sn[i];
    step();
    step();
    rst_n = 1'b1;
    src_add(3, 'h0B03, 1); src_add(1, 'h0B01, 1); src_add(0, 'h0B00, 1);
    exp_add(0, 'h0B00, 1); exp_add(1, 'h0B01, 1); exp_add(3, 'h0B03, 1);
    wait_drain("post_reset", 50);

    step();
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
